alu_cmd_seq: RTL

//   Command front-end and result stage for the 4-bit combinational ALU.

---
 rtl/alu_cmd_seq.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_seq.sv
// ============================================================================
// Module   : alu_cmd_seq
// Brief    : Command FIFO, operand registers and result stage for a 4-bit ALU.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_cmd_seq #(
    parameter int DW    = 4,
    parameter int OPW   = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [OPW-1:0]           cmd_opr,
    input  logic [DW-1:0]            cmd_a,
    input  logic [DW-1:0]            cmd_b,
    output logic [OPW-1:0]           alu_opr,
    output logic [DW-1:0]            alu_a,
    output logic [DW-1:0]            alu_b,
    input  logic [DW-1:0]            alu_o,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DW-1:0]            res_data,
    output logic [OPW-1:0]           res_opr,
    output logic                     res_zero,
    output logic                     res_dz,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = OPW + 2 * DW;

    localparam logic [CW-1:0]  c_FULL   = CW'(DEPTH);
    localparam logic [OPW-1:0] c_OP_DIV = OPW'(3);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [EW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_state;

    logic [OPW-1:0] r_alu_opr;
    logic [DW-1:0]  r_alu_a;
    logic [DW-1:0]  r_alu_b;

    logic           r_res_valid;
    logic [DW-1:0]  r_res_data;
    logic [OPW-1:0] r_res_opr;
    logic           r_res_zero;
    logic           r_res_dz;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic           w_cmd_ready;
    logic           w_push;
    logic           w_not_empty;
    logic [1:0]     w_state_nxt;
    logic           w_pop;
    logic           w_capture;
    logic           w_release;
    logic [EW-1:0]  w_head;
    logic           w_dz;
    logic [DW-1:0]  w_res;

    // Ready is a pure function of the occupancy register, so a pop in the
    // same cycle never opens a slot for a push on a full FIFO.
    assign w_cmd_ready = (r_cnt != c_FULL);
    assign w_push      = cmd_valid & w_cmd_ready;
    assign w_not_empty = (r_cnt != '0);
    assign w_head      = r_mem[r_rd_ptr];

    assign w_dz  = (r_alu_opr == c_OP_DIV) && (r_alu_b == '0);
    assign w_res = w_dz ? '0 : alu_o;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_not_empty) begin
                    w_state_nxt = c_EXEC;
                end
            end
            c_EXEC: begin
                w_state_nxt = c_WAIT;
            end
            c_WAIT: begin
                if (res_ready) begin
                    w_state_nxt = w_not_empty ? c_EXEC : c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_release = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_pop = w_not_empty;
            end
            c_EXEC: begin
                w_capture = 1'b1;
            end
            c_WAIT: begin
                w_release = res_ready;
                w_pop     = res_ready & w_not_empty;
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command FIFO storage (data only, no reset needed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_opr, cmd_a, cmd_b};
        end
    end

    // Pop decisions use the registered count, so an entry written this
    // cycle can never be read in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // ALU operand registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_opr <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
        end else if (w_pop) begin
            r_alu_opr <= w_head[EW-1 -: OPW];
            r_alu_a   <= w_head[2*DW-1 -: DW];
            r_alu_b   <= w_head[DW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Result stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_opr   <= '0;
            r_res_zero  <= 1'b0;
            r_res_dz    <= 1'b0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_res;
            r_res_opr   <= r_alu_opr;
            r_res_zero  <= (w_res == '0);
            r_res_dz    <= w_dz;
        end else if (w_release) begin
            r_res_valid <= 1'b0;
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign fifo_cnt  = r_cnt;
    assign alu_opr   = r_alu_opr;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_opr   = r_res_opr;
    assign res_zero  = r_res_zero;
    assign res_dz    = r_res_dz;

endmodule

`default_nettype wire
